// File: rtl/mem_port_arbiter.sv
// Two-port round-robin arbiter in front of the unified 16-bit memory.
// Serialises CPU (C) and loader (D) accesses: grant, strobe, wait out MEM_LAT, ack.
module mem_port_arbiter #(
  parameter int MEM_LAT = 2,
  parameter int AW      = 16,
  parameter int DW      = 16
) (
  input  logic          CLK,
  input  logic          Reset,
  input  logic          c_req,
  input  logic          c_we,
  input  logic [AW-1:0] c_addr,
  input  logic [DW-1:0] c_wdata,
  output logic          c_ack,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_ack,
  output logic [DW-1:0] rdata,
  output logic          owner,
  output logic          busy,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_re,
  output logic          mem_we,
  input  logic [DW-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_ACK   = 2'd3
  } state_t;

  localparam logic [3:0] LAT = 4'(MEM_LAT);

  state_t        state_q, state_d;
  logic          owner_q, owner_d;
  logic          last_grant_q, last_grant_d;
  logic          we_q, we_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic [3:0]    wait_cnt_q, wait_cnt_d;
  logic          c_ack_q, c_ack_d;
  logic          d_ack_q, d_ack_d;
  logic          mem_re_q, mem_re_d;
  logic          mem_we_q, mem_we_d;
  logic          busy_q, busy_d;
  logic          gnt;

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q      <= S_IDLE;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      we_q         <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      rdata_q      <= '0;
      wait_cnt_q   <= '0;
      c_ack_q      <= 1'b0;
      d_ack_q      <= 1'b0;
      mem_re_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      we_q         <= we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      rdata_q      <= rdata_d;
      wait_cnt_q   <= wait_cnt_d;
      c_ack_q      <= c_ack_d;
      d_ack_q      <= d_ack_d;
      mem_re_q     <= mem_re_d;
      mem_we_q     <= mem_we_d;
      busy_q       <= busy_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    we_d         = we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    rdata_d      = rdata_q;
    wait_cnt_d   = wait_cnt_q;
    c_ack_d      = 1'b0;
    d_ack_d      = 1'b0;
    mem_re_d     = 1'b0;
    mem_we_d     = 1'b0;
    gnt          = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (c_req || d_req) begin
          // On a tie the port that did not win last time gets the memory
          gnt          = (c_req && d_req) ? ~last_grant_q : d_req;
          owner_d      = gnt;
          last_grant_d = gnt;
          we_d         = gnt ? d_we : c_we;
          mem_addr_d   = gnt ? d_addr : c_addr;
          mem_wdata_d  = gnt ? d_wdata : c_wdata;
          // Strobes are registered here so they are high during ISSUE
          mem_re_d     = ~we_d;
          mem_we_d     = we_d;
          state_d      = S_ISSUE;
        end
      end
      S_ISSUE: begin
        wait_cnt_d = LAT;
        state_d    = S_WAIT;
      end
      S_WAIT: begin
        wait_cnt_d = wait_cnt_q - 4'd1;
        if (wait_cnt_q == 4'd1) begin
          if (!we_q) rdata_d = mem_rdata;
          c_ack_d = ~owner_q;
          d_ack_d = owner_q;
          state_d = S_ACK;
        end
      end
      S_ACK: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  assign c_ack     = c_ack_q;
  assign d_ack     = d_ack_q;
  assign rdata     = rdata_q;
  assign owner     = owner_q;
  assign busy      = busy_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_re    = mem_re_q;
  assign mem_we    = mem_we_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: two autonomous requesters, a latency memory,
// and a transaction-schedule model compared against every output each cycle.
module tb_mem_port_arbiter;
  localparam int LAT = 2;
  localparam int AW  = 16;
  localparam int DW  = 16;

  logic          CLK = 1'b0;
  logic          Reset;
  logic          c_req, c_we, d_req, d_we;
  logic [AW-1:0] c_addr, d_addr, mem_addr;
  logic [DW-1:0] c_wdata, d_wdata, rdata, mem_wdata, mem_rdata;
  logic          c_ack, d_ack, owner, busy, mem_re, mem_we;

  mem_port_arbiter #(.MEM_LAT(LAT), .AW(AW), .DW(DW)) dut (
    .CLK(CLK), .Reset(Reset),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata), .c_ack(c_ack),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_ack(d_ack),
    .rdata(rdata), .owner(owner), .busy(busy),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_re(mem_re), .mem_we(mem_we),
    .mem_rdata(mem_rdata)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    int            gap;
  } txn_t;

  txn_t cq[$];
  txn_t dq[$];
  int   c_idx, d_idx;
  logic c_drv, d_drv;

  function automatic logic [DW-1:0] init_f(input logic [AW-1:0] a);
    if (a == 16'h0010) return 16'hBEEF;
    if (a == 16'h0040) return 16'hCAFE;
    return (a * 16'h9E37) ^ 16'h5A5A;
  endfunction

  // Memory: read data appears LAT cycles after the strobe cycle, junk otherwise
  logic [DW-1:0] mem   [0:65535];
  bit            mem_v [0:65535];
  logic [DW-1:0] pipe  [0:LAT-1];

  always @(posedge CLK) begin
    if (mem_we === 1'b1) begin
      mem[mem_addr]   <= mem_wdata;
      mem_v[mem_addr] <= 1'b1;
    end
    if (mem_re === 1'b1)
      pipe[0] <= mem_v[mem_addr] ? mem[mem_addr] : init_f(mem_addr);
    else
      pipe[0] <= DW'($urandom);
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign mem_rdata = pipe[LAT-1];

  // Port C requester: holds req until ack (or a reset aborts it)
  initial begin
    txn_t t;
    c_req = 1'b0; c_we = 1'b0; c_addr = '0; c_wdata = '0; c_idx = 0; c_drv = 1'b0;
    forever begin
      while (c_idx >= cq.size()) @(posedge CLK);
      t = cq[c_idx];
      c_idx++;
      c_drv = 1'b1;
      repeat (t.gap) @(posedge CLK);
      #1;
      c_req = 1'b1; c_we = t.we; c_addr = t.addr; c_wdata = t.wdata;
      for (int k = 0; k < 200; k++) begin
        @(negedge CLK);
        if (c_ack || Reset) break;
      end
      @(posedge CLK);
      #1;
      c_req = 1'b0;
      c_drv = 1'b0;
    end
  end

  // Port D requester
  initial begin
    txn_t t;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0; d_idx = 0; d_drv = 1'b0;
    forever begin
      while (d_idx >= dq.size()) @(posedge CLK);
      t = dq[d_idx];
      d_idx++;
      d_drv = 1'b1;
      repeat (t.gap) @(posedge CLK);
      #1;
      d_req = 1'b1; d_we = t.we; d_addr = t.addr; d_wdata = t.wdata;
      for (int k = 0; k < 200; k++) begin
        @(negedge CLK);
        if (d_ack || Reset) break;
      end
      @(posedge CLK);
      #1;
      d_req = 1'b0;
      d_drv = 1'b0;
    end
  end

  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;
  logic rst_next = 1'b1;
  bit   seen_rst = 1'b0;

  // Model: one transaction in flight, described by its grant cycle
  bit            t_act = 1'b0;
  int            t_g, free_c;
  logic          t_we, t_own;
  logic [DW-1:0] t_rdv;
  logic          m_last, m_own;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata, m_rdata;
  logic [DW-1:0] sh   [0:65535];
  bit            sh_v [0:65535];

  int            creq_first, dreq_first, re_cyc, re_n, we_n;
  int            cack_cyc, dack_cyc, cack_n, dack_n, n_acks;
  logic [AW-1:0] re_addr, we_addr;
  logic [DW-1:0] we_data, cack_rd, dack_rd;
  logic          ack_own [0:15];
  logic [DW-1:0] ack_rd  [0:15];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cycle %0d: got %0h, expected %0h", nm, cyc, act, exp);
    end
  endtask

  task automatic clr_mon();
    creq_first = -1; dreq_first = -1; re_cyc = -1; re_n = 0; we_n = 0;
    cack_cyc = -1; dack_cyc = -1; cack_n = 0; dack_n = 0; n_acks = 0;
    re_addr = '0; we_addr = '0; we_data = '0; cack_rd = '0; dack_rd = '0;
  endtask

  task automatic tick();
    logic e_re, e_we, e_ca, e_da, e_busy, g;
    @(posedge CLK);
    #1;
    Reset = rst_next;
    @(negedge CLK);
    cyc++;
    e_re = 1'b0; e_we = 1'b0; e_ca = 1'b0; e_da = 1'b0; e_busy = 1'b0;
    if (t_act) begin
      if (cyc == t_g + 1) begin
        e_re = ~t_we;
        e_we = t_we;
      end
      e_busy = (cyc > t_g) && (cyc <= t_g + LAT + 2);
      if (cyc == t_g + LAT + 2) begin
        e_ca = ~t_own;
        e_da = t_own;
        if (!t_we) m_rdata = t_rdv;
        t_act = 1'b0;
      end
    end
    if (seen_rst) begin
      chk("c_ack",     32'(c_ack),     32'(e_ca));
      chk("d_ack",     32'(d_ack),     32'(e_da));
      chk("mem_re",    32'(mem_re),    32'(e_re));
      chk("mem_we",    32'(mem_we),    32'(e_we));
      chk("busy",      32'(busy),      32'(e_busy));
      chk("owner",     32'(owner),     32'(m_own));
      chk("mem_addr",  32'(mem_addr),  32'(m_addr));
      chk("mem_wdata", 32'(mem_wdata), 32'(m_wdata));
      chk("rdata",     32'(rdata),     32'(m_rdata));
    end
    if (c_req && creq_first < 0) creq_first = cyc;
    if (d_req && dreq_first < 0) dreq_first = cyc;
    if (mem_re === 1'b1) begin re_n++; re_cyc = cyc; re_addr = mem_addr; end
    if (mem_we === 1'b1) begin we_n++; we_addr = mem_addr; we_data = mem_wdata; end
    if (c_ack === 1'b1) begin cack_n++; cack_cyc = cyc; cack_rd = rdata; end
    if (d_ack === 1'b1) begin dack_n++; dack_cyc = cyc; dack_rd = rdata; end
    if (c_ack === 1'b1 || d_ack === 1'b1) begin
      if (n_acks < 16) begin
        ack_own[n_acks] = d_ack;
        ack_rd[n_acks]  = rdata;
      end
      n_acks++;
    end
    // Advance the model to describe the next cycle
    if (Reset) begin
      seen_rst = 1'b1;
      t_act = 1'b0; free_c = cyc + 1;
      m_last = 1'b1; m_own = 1'b0; m_addr = '0; m_wdata = '0; m_rdata = '0;
    end else if (seen_rst && cyc >= free_c && (c_req || d_req)) begin
      g      = (c_req && d_req) ? ~m_last : d_req;
      t_act  = 1'b1;
      t_g    = cyc;
      free_c = cyc + LAT + 3;
      t_own  = g;
      m_own  = g;
      m_last = g;
      t_we   = g ? d_we : c_we;
      m_addr = g ? d_addr : c_addr;
      m_wdata = g ? d_wdata : c_wdata;
      if (t_we) begin
        sh[m_addr]   = m_wdata;
        sh_v[m_addr] = 1'b1;
      end else begin
        t_rdv = sh_v[m_addr] ? sh[m_addr] : init_f(m_addr);
      end
    end
  endtask

  task automatic run_until_acks(input int n, input int budget);
    int k = 0;
    while ((cack_n + dack_n) < n && k < budget) begin
      tick();
      k++;
    end
    chk("ack_wait_timeout", 32'((cack_n + dack_n) >= n), 32'd1);
  endtask

  initial begin
    int   k;
    txn_t t;
    Reset = 1'b1;
    clr_mon();

    // Reset held three cycles
    rst_next = 1'b1;
    repeat (3) tick();
    rst_next = 1'b0;
    chk("rst_busy",      32'(busy),      32'd0);
    chk("rst_owner",     32'(owner),     32'd0);
    chk("rst_c_ack",     32'(c_ack),     32'd0);
    chk("rst_d_ack",     32'(d_ack),     32'd0);
    chk("rst_mem_re",    32'(mem_re),    32'd0);
    chk("rst_mem_we",    32'(mem_we),    32'd0);
    chk("rst_rdata",     32'(rdata),     32'd0);
    chk("rst_mem_addr",  32'(mem_addr),  32'd0);
    chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);

    // Single C read of 0x0010
    clr_mon();
    cq.push_back('{1'b0, 16'h0010, 16'h0000, 0});
    run_until_acks(1, 30);
    repeat (3) tick();
    chk("rd_strobe_cycle", 32'(re_cyc - creq_first),   32'd1);
    chk("rd_strobe_count", 32'(re_n),                  32'd1);
    chk("rd_addr",         32'(re_addr),               32'h0010);
    chk("rd_ack_latency",  32'(cack_cyc - creq_first), 32'd4);
    chk("rd_ack_count",    32'(cack_n),                32'd1);
    chk("rd_no_dack",      32'(dack_n),                32'd0);
    chk("rd_no_write",     32'(we_n),                  32'd0);
    chk("rd_data",         32'(cack_rd),               32'hBEEF);

    // Single D write of 0x1234 to 0x0200
    clr_mon();
    dq.push_back('{1'b1, 16'h0200, 16'h1234, 0});
    run_until_acks(1, 30);
    repeat (3) tick();
    chk("wr_strobe_count", 32'(we_n),                  32'd1);
    chk("wr_addr",         32'(we_addr),               32'h0200);
    chk("wr_data",         32'(we_data),               32'h1234);
    chk("wr_ack_latency",  32'(dack_cyc - dreq_first), 32'd4);
    chk("wr_no_cack",      32'(cack_n),                32'd0);
    chk("wr_no_read",      32'(re_n),                  32'd0);
    chk("wr_rdata_kept",   32'(dack_rd),               32'hBEEF);

    // Tie straight after reset: C first, D one access period later
    rst_next = 1'b1;
    repeat (2) tick();
    rst_next = 1'b0;
    clr_mon();
    cq.push_back('{1'b0, 16'h0020, 16'h0000, 0});
    dq.push_back('{1'b0, 16'h0030, 16'h0000, 0});
    run_until_acks(2, 40);
    repeat (2) tick();
    chk("tie_first_owner",  32'(ack_own[0]),            32'd0);
    chk("tie_second_owner", 32'(ack_own[1]),            32'd1);
    chk("tie_c_latency",    32'(cack_cyc - creq_first), 32'd4);
    chk("tie_d_after_c",    32'(dack_cyc - cack_cyc),   32'(LAT + 3));

    // Continuous traffic from both ports, including address 0xFFFF
    clr_mon();
    cq.push_back('{1'b1, 16'hFFFF, 16'h5555, 0});
    cq.push_back('{1'b0, 16'hFFFF, 16'h0000, 0});
    cq.push_back('{1'b0, 16'h0010, 16'h0000, 0});
    cq.push_back('{1'b1, 16'h0011, 16'hABCD, 0});
    dq.push_back('{1'b0, 16'h0100, 16'h0000, 0});
    dq.push_back('{1'b0, 16'h0101, 16'h0000, 0});
    dq.push_back('{1'b1, 16'h0102, 16'h7777, 0});
    dq.push_back('{1'b0, 16'h0102, 16'h0000, 0});
    run_until_acks(8, 100);
    repeat (3) tick();
    chk("cont_ack_total", 32'(n_acks), 32'd8);
    for (int i = 0; i < 8; i++) chk($sformatf("cont_owner_%0d", i), 32'(ack_own[i]), 32'(i % 2));
    chk("cont_ffff_rd", 32'(ack_rd[2]), 32'h5555);
    chk("cont_raw_rd",  32'(ack_rd[7]), 32'h7777);

    // Reset during WAIT of a read aborts it; the retry completes
    clr_mon();
    cq.push_back('{1'b0, 16'h0040, 16'h0000, 0});
    k = 0;
    while (re_n == 0 && k < 30) begin tick(); k++; end
    chk("abort_strobe_seen", 32'(re_n), 32'd1);
    rst_next = 1'b1;
    tick();
    rst_next = 1'b0;
    tick();
    chk("abort_busy",  32'(busy),  32'd0);
    chk("abort_rdata", 32'(rdata), 32'd0);
    chk("abort_c_ack", 32'(c_ack), 32'd0);
    repeat (6) tick();
    chk("abort_no_ack", 32'(cack_n), 32'd0);
    cq.push_back('{1'b0, 16'h0040, 16'h0000, 0});
    run_until_acks(1, 30);
    chk("retry_data", 32'(cack_rd), 32'hCAFE);

    // Randomised traffic checked by the model alone
    for (int i = 0; i < 40; i++) begin
      t.we    = 1'($urandom_range(0, 1));
      t.addr  = ($urandom_range(0, 4) == 0) ? 16'hFFFF : 16'(16'h0300 + $urandom_range(0, 15));
      t.wdata = 16'($urandom);
      t.gap   = $urandom_range(0, 4);
      cq.push_back(t);
      t.we    = 1'($urandom_range(0, 1));
      t.addr  = ($urandom_range(0, 4) == 0) ? 16'hFFFF : 16'(16'h0300 + $urandom_range(0, 15));
      t.wdata = 16'($urandom);
      t.gap   = $urandom_range(0, 4);
      dq.push_back(t);
    end
    k = 0;
    while (!(c_idx == cq.size() && d_idx == dq.size() && !c_drv && !d_drv && !busy) && k < 3000) begin
      tick();
      k++;
    end
    chk("random_drain", 32'(k < 3000), 32'd1);
    repeat (3) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
